// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the alu_muldiv execute unit: op codes, FSM states
// and op-class helpers.
package alu_muldiv_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_AND    = 5'b00010,
    OP_OR     = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SLL    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_SLTU   = 5'b01000,
    OP_SLT    = 5'b01001,
    OP_EQ     = 5'b01010,
    OP_LT     = 5'b01011,
    OP_LTU    = 5'b01100,
    OP_GE     = 5'b01101,
    OP_GEU    = 5'b01110,
    OP_PASSB  = 5'b01111,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider core on unsigned magnitudes; one quotient bit per
// cycle. quo_o/rem_o present the post-step values so the caller can register
// them in the cycle done_o is high.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_mag_i,
  input  logic [XLEN-1:0] b_mag_i,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);
  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [XLEN-1:0] quo_d, rem_d;
  logic [XLEN:0]   rem_sh_s, diff_s;

  // Trial subtraction; the dividend shifts out of quo_q as quotient bits shift in.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, div_q};
    if (diff_s[XLEN]) begin
      rem_d = rem_sh_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = diff_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(XLEN-1));
  assign quo_o  = quo_d;
  assign rem_o  = rem_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      quo_q  <= {XLEN{1'b0}};
      rem_q  <= {XLEN{1'b0}};
      div_q  <= {XLEN{1'b0}};
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= {CW{1'b0}};
      quo_q  <= a_mag_i;
      rem_q  <= {XLEN{1'b0}};
      div_q  <= b_mag_i;
    end else if (busy_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= !done_o;
    end else begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// RV integer ALU plus RV-M multiply/divide execute unit with valid/ready
// handshakes; ALU/MUL complete in one cycle, DIV/REM iterate XLEN cycles.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SHW    = $clog2(XLEN),
  parameter bit DIV_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);
  state_e            state_q;
  logic              out_valid_q, zero_q, illegal_q;
  logic [XLEN-1:0]   result_q;
  logic              quo_neg_q, rem_neg_q, rem_sel_q;

  logic              accept_s, div_op_s, div_sgn_s, a_neg_s, b_neg_s;
  logic              a_sgn_s, b_sgn_s, div_done_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, quo_s, rem_s;
  logic [XLEN-1:0]   alu_res_d, div_res_d;
  logic              alu_ill_d;
  logic [2*XLEN-1:0] ma_s, mb_s, prod_s;
  logic [SHW-1:0]    shamt_s;

  assign in_ready_o = !reset_i && (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
  assign accept_s   = in_valid_i && in_ready_o;
  assign div_op_s   = DIV_EN && is_div(op_i);
  assign div_sgn_s  = div_op_s && !op_i[0];
  assign a_neg_s    = div_sgn_s && a_i[XLEN-1];
  assign b_neg_s    = div_sgn_s && b_i[XLEN-1];
  assign a_mag_s    = a_neg_s ? -a_i : a_i;
  assign b_mag_s    = b_neg_s ? -b_i : b_i;
  assign shamt_s    = b_i[SHW-1:0];

  // Extending both operands to 2*XLEN makes the wrapped product's upper half exact.
  assign a_sgn_s = is_mul(op_i) && (op_i != OP_MULHU);
  assign b_sgn_s = (op_i == OP_MUL) || (op_i == OP_MULH);
  assign ma_s    = {{XLEN{a_i[XLEN-1] & a_sgn_s}}, a_i};
  assign mb_s    = {{XLEN{b_i[XLEN-1] & b_sgn_s}}, b_i};
  assign prod_s  = ma_s * mb_s;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (accept_s && div_op_s),
    .a_mag_i (a_mag_s),
    .b_mag_i (b_mag_s),
    .done_o  (div_done_s),
    .quo_o   (quo_s),
    .rem_o   (rem_s)
  );

  always_comb begin
    if (rem_sel_q) begin
      div_res_d = rem_neg_q ? -rem_s : rem_s;
    end else begin
      div_res_d = quo_neg_q ? -quo_s : quo_s;
    end
  end

  always_comb begin
    alu_res_d = {XLEN{1'b0}};
    alu_ill_d = 1'b0;
    case (op_i)
      OP_ADD:    alu_res_d = a_i + b_i;
      OP_SUB:    alu_res_d = a_i - b_i;
      OP_AND:    alu_res_d = a_i & b_i;
      OP_OR:     alu_res_d = a_i | b_i;
      OP_XOR:    alu_res_d = a_i ^ b_i;
      OP_SLL:    alu_res_d = a_i << shamt_s;
      OP_SRL:    alu_res_d = a_i >> shamt_s;
      OP_SRA:    alu_res_d = $signed(a_i) >>> shamt_s;
      OP_SLTU,
      OP_LTU:    alu_res_d = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_SLT,
      OP_LT:     alu_res_d = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_EQ:     alu_res_d = {{(XLEN-1){1'b0}}, (a_i == b_i)};
      OP_GE:     alu_res_d = {{(XLEN-1){1'b0}}, ($signed(a_i) >= $signed(b_i))};
      OP_GEU:    alu_res_d = {{(XLEN-1){1'b0}}, (a_i >= b_i)};
      OP_PASSB:  alu_res_d = b_i;
      OP_MUL:    alu_res_d = prod_s[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res_d = prod_s[2*XLEN-1:XLEN];
      default:   alu_ill_d = 1'b1;
    endcase
  end

  // Control FSM and output register; accepting a divide always empties the
  // output slot since acceptance implies it was empty or being consumed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      rem_sel_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && div_op_s) begin
            state_q     <= ST_BUSY;
            out_valid_q <= 1'b0;
            quo_neg_q   <= (a_neg_s ^ b_neg_s) && (b_i != {XLEN{1'b0}});
            rem_neg_q   <= a_neg_s;
            rem_sel_q   <= op_i[1];
          end else if (accept_s) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            zero_q      <= (alu_res_d == {XLEN{1'b0}});
            illegal_q   <= alu_ill_d;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (div_done_s) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            result_q    <= div_res_d;
            zero_q      <= (div_res_d == {XLEN{1'b0}});
            illegal_q   <= 1'b0;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;

endmodule
